// File: rtl/conv_decoder_pe_array_acc.sv
// -----------------------------------------------------------------------------
// conv_decoder_pe_array_acc
//
// Decoder convolution PE array. LANES signed multipliers feed a pipelined
// binary adder tree. A multi-beat accumulator adds up all channel groups of
// one output pixel. The pixel total is then requantised: bias add,
// round-half-up, saturation to DW bits, and optional ReLU. The result is held
// in a single-slot output register with valid/ready handshaking.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          beat present on x_flat/w_flat
//   in_ready   out  1          beat accepted this cycle when in_valid=1
//   in_last    in   1          beat is the final channel group of the pixel
//   x_flat     in   LANES*DW   activations, lane i = bits [i*DW +: DW]
//   w_flat     in   LANES*DW   weights, same packing
//   bias       in   DW         pixel bias (used with the in_last beat)
//   relu_en    in   1          clamp negative results to 0 (used with in_last)
//   out_valid  out  1          out_pixel/out_sat valid
//   out_ready  in   1          downstream accepts the result
//   out_pixel  out  DW         requantised result
//   out_sat    out  1          result was clamped to the DW range
//   busy       out  1          beat in flight, partial sum held or output pending
//
// Arithmetic: x, w, bias and out_pixel are Q(DW-FRAC).FRAC. Each product and
// the accumulated sum are Q.(2*FRAC). Requantisation therefore shifts right
// by FRAC and rounds by adding half an output LSB.
// -----------------------------------------------------------------------------
module conv_decoder_pe_array_acc #(
  parameter int LANES = 16,
  parameter int DW    = 18,
  parameter int FRAC  = 9,
  parameter int ACC_W = 48,
  parameter int CH_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   x_flat,
  input  logic [LANES*DW-1:0]   w_flat,
  input  logic [DW-1:0]         bias,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_pixel,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int L     = $clog2(LANES);
  localparam int NODES = 2 * LANES;

  // Half an output LSB at the Q.(2*FRAC) scale.
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [CH_W-1:0] CNT_MAX = {CH_W{1'b1}};
  localparam logic [CH_W-1:0] CNT_ONE = {{(CH_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Sign-extends one DW-bit lane operand to the 2*DW product width.
  function automatic logic signed [2*DW-1:0] sext_lane(input logic [DW-1:0] v);
    sext_lane = {{DW{v[DW-1]}}, v};
  endfunction

  // Sign-extends a 2*DW product to the accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic [2*DW-1:0] v);
    sext_prod = {{(ACC_W-2*DW){v[2*DW-1]}}, v};
  endfunction

  logic                     en_s;
  logic signed [2*DW-1:0]   prod_s [LANES];

  // The adder tree is stored heap-style. Leaves sit at LANES..2*LANES-1, and
  // node n reduces nodes 2n and 2n+1. Every node is a register, so each tree
  // level is one pipeline stage, and the root node_r[1] is L stages past the
  // leaves.
  logic signed [ACC_W-1:0]  node_r [1:NODES-1];

  // Tag pipeline. Index 0 is aligned with the leaves and index L with the root.
  logic [L:0]               v_r;
  logic [L:0]               last_r;
  logic [L:0]               relu_r;
  logic [DW-1:0]            bias_r [L+1];

  state_t                   state_r;
  state_t                   state_n;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_n;
  logic [CH_W-1:0]          cnt_r;
  logic [CH_W-1:0]          cnt_n;
  logic                     emit_s;
  logic signed [ACC_W-1:0]  total_s;

  logic signed [ACC_W-1:0]  bias_sh_s;
  logic signed [ACC_W-1:0]  round_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic signed [ACC_W-1:0]  clamped_s;
  logic [DW-1:0]            pixel_s;
  logic                     sat_s;

  logic                     out_valid_r;
  logic [DW-1:0]            out_pixel_r;
  logic                     out_sat_r;

  // The whole array stalls only when a result is waiting and downstream refuses it.
  assign en_s     = !(out_valid_r && !out_ready);
  assign in_ready = en_s;

  assign out_valid = out_valid_r;
  assign out_pixel = out_pixel_r;
  assign out_sat   = out_sat_r;
  assign busy      = (|v_r) || (state_r == ACCUM) || out_valid_r;

  // Per-lane signed multipliers.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_s[i] = sext_lane(x_flat[i*DW +: DW]) * sext_lane(w_flat[i*DW +: DW]);
    end
  end

  // Product registers, adder-tree levels and the tags that travel with each beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 1; n < NODES; n++) begin
        node_r[n] <= {ACC_W{1'b0}};
      end
      v_r    <= {(L+1){1'b0}};
      last_r <= {(L+1){1'b0}};
      relu_r <= {(L+1){1'b0}};
      for (int s = 0; s <= L; s++) begin
        bias_r[s] <= {DW{1'b0}};
      end
    end else if (en_s) begin
      for (int n = 1; n < LANES; n++) begin
        node_r[n] <= node_r[2*n] + node_r[2*n+1];
      end
      for (int i = 0; i < LANES; i++) begin
        node_r[LANES+i] <= sext_prod(prod_s[i]);
      end
      // in_ready equals en_s, so in_valid here means the beat was accepted.
      v_r    <= {v_r[L-1:0], in_valid};
      last_r <= {last_r[L-1:0], in_last};
      relu_r <= {relu_r[L-1:0], relu_en};
      bias_r[0] <= bias;
      for (int s = 1; s <= L; s++) begin
        bias_r[s] <= bias_r[s-1];
      end
    end
  end

  // Accumulator FSM: next state, partial-sum update and the emit decision.
  always_comb begin
    state_n = state_r;
    acc_n   = acc_r;
    cnt_n   = cnt_r;
    emit_s  = 1'b0;
    total_s = node_r[1];
    if (v_r[L]) begin
      case (state_r)
        IDLE: begin
          total_s = node_r[1];
          if (last_r[L]) begin
            emit_s  = 1'b1;
            state_n = IDLE;
          end else begin
            acc_n   = node_r[1];
            cnt_n   = CNT_ONE;
            state_n = ACCUM;
          end
        end
        ACCUM: begin
          total_s = acc_r + node_r[1];
          if (last_r[L]) begin
            emit_s  = 1'b1;
            acc_n   = {ACC_W{1'b0}};
            cnt_n   = {CH_W{1'b0}};
            state_n = IDLE;
          end else begin
            acc_n   = total_s;
            cnt_n   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
            state_n = ACCUM;
          end
        end
        default: begin
          acc_n   = {ACC_W{1'b0}};
          cnt_n   = {CH_W{1'b0}};
          state_n = IDLE;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Requantisation: bias at the product scale, round half up, saturate, then ReLU.
  always_comb begin
    bias_sh_s = {{(ACC_W-DW){bias_r[L][DW-1]}}, bias_r[L]} <<< FRAC;
    round_s   = total_s + bias_sh_s + RND_HALF;
    shifted_s = round_s >>> FRAC;
    clamped_s = shifted_s;
    sat_s     = 1'b0;
    if (shifted_s > OUT_MAX) begin
      clamped_s = OUT_MAX;
      sat_s     = 1'b1;
    end else if (shifted_s < OUT_MIN) begin
      clamped_s = OUT_MIN;
      sat_s     = 1'b1;
    end else begin
      clamped_s = shifted_s;
    end
    // ReLU acts after clamping, so a clamped negative still reports out_sat.
    if (relu_r[L] && clamped_s[ACC_W-1]) begin
      pixel_s = {DW{1'b0}};
    end else begin
      pixel_s = clamped_s[DW-1:0];
    end
  end

  // Accumulator FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CH_W{1'b0}};
    end else if (en_s) begin
      state_r <= state_n;
      acc_r   <= acc_n;
      cnt_r   <= cnt_n;
    end
  end

  // Single-slot output register. When en_s is high, any held result is being
  // taken this edge, so out_valid simply follows emit_s.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_pixel_r <= {DW{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= emit_s;
      if (emit_s) begin
        out_pixel_r <= pixel_s;
        out_sat_r   <= sat_s;
      end
    end
  end

endmodule

// File: tb/tb_conv_decoder_pe_array_acc.sv
// Self-checking bench for conv_decoder_pe_array_acc. The stimulus pushes
// hand-computed results into a queue, and a negedge monitor pops and compares
// them on every output handshake.
module tb_conv_decoder_pe_array_acc;
  localparam int LANES = 16;
  localparam int DW    = 18;
  localparam int FRAC  = 9;
  localparam int ACC_W = 48;
  localparam int CH_W  = 8;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [LANES*DW-1:0]  x_flat;
  logic [LANES*DW-1:0]  w_flat;
  logic [DW-1:0]        bias;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_pixel;
  logic                 out_sat;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  logic [DW:0] exp_q [$];

  conv_decoder_pe_array_acc #(
    .LANES(LANES), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .x_flat(x_flat), .w_flat(w_flat), .bias(bias),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sat(out_sat), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LANES*DW-1:0] all_lanes(input logic [DW-1:0] v);
    all_lanes = {LANES{v}};
  endfunction

  function automatic logic [LANES*DW-1:0] lane0(input logic [DW-1:0] v);
    lane0 = {{((LANES-1)*DW){1'b0}}, v};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] pix, input logic sat);
    exp_q.push_back({sat, pix});
    pushed++;
  endtask

  // Drives one beat and holds it until the handshake completes (bounded).
  task automatic send(input logic [LANES*DW-1:0] x, input logic [LANES*DW-1:0] w,
                      input logic last, input logic [DW-1:0] b, input logic r);
    logic ok;
    int   t;
    x_flat = x; w_flat = w; in_last = last; bias = b; relu_en = r;
    in_valid = 1'b1;
    t = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard monitor: a result is transferred on the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [DW:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got pixel=%0d sat=%0b, expected none",
                 $signed(out_pixel), out_sat);
      end else begin
        e = exp_q.pop_front();
        popped++;
        if ({out_sat, out_pixel} !== e) begin
          errors++;
          $display("FAIL output_%0d: got pixel=%0d sat=%0b, expected pixel=%0d sat=%0b",
                   popped, $signed(out_pixel), out_sat, $signed(e[DW-1:0]), e[DW]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected completion within 500000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; x_flat = '0; w_flat = '0;
    bias = '0; relu_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_sat",   out_sat, 0);
    chk("rst_busy",      busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Test 1: 16 * 1.0 * 1.0 = 16.0 -> 8192, visible after edge k+5.
    push(18'd8192, 1'b0);
    send(all_lanes(18'd512), all_lanes(18'd512), 1'b1, 18'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_no_valid_k4", out_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid_k5", out_valid, 1);
    repeat (3) @(posedge clk);
    #1;

    // Test 2: three beats of 16*0.5 = 8.0 -> 24.0, plus bias 1.0 -> 25.0 = 12800.
    send(all_lanes(18'd512), all_lanes(18'd256), 1'b0, 18'd0, 1'b0);
    send(all_lanes(18'd512), all_lanes(18'd256), 1'b0, 18'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_no_early_output", out_valid, 0);
    chk("t2_busy_accum", busy, 1);
    push(18'd12800, 1'b0);
    send(all_lanes(18'd512), all_lanes(18'd256), 1'b1, 18'd512, 1'b0);

    // Test 3: positive and negative saturation, with ReLU on the negative case.
    push(18'h1FFFF, 1'b1);
    send(all_lanes(18'h1FFFF), all_lanes(18'h1FFFF), 1'b1, 18'd0, 1'b0);
    push(18'd0, 1'b1);
    send(all_lanes(18'h20000), all_lanes(18'h1FFFF), 1'b1, 18'd0, 1'b1);

    // Test 4: rounding at exactly half an LSB, and just below it.
    push(18'd1, 1'b0);
    send(lane0(18'd1), lane0(18'd256), 1'b1, 18'd0, 1'b0);
    push(18'd0, 1'b0);
    send(lane0(18'h3FFFF), lane0(18'd256), 1'b1, 18'd0, 1'b0);
    push(18'h3FFFF, 1'b0);
    send(lane0(18'h3FFFF), lane0(18'd257), 1'b1, 18'd0, 1'b0);
    repeat (8) @(posedge clk);
    #1;

    // Test 5: eight single-beat pixels while downstream stalls for 10 cycles.
    fork
      begin
        out_ready = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t5_in_ready_stalled", in_ready, 0);
        chk("t5_out_valid_held", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        for (int k = 1; k <= 8; k++) begin
          logic [DW-1:0] xv;
          xv = DW'(k * 512);
          push(DW'(k * 512), 1'b0);
          send(lane0(xv), lane0(18'd512), 1'b1, 18'd0, 1'b0);
        end
      end
    join
    repeat (10) @(posedge clk);
    #1;

    // Test 6: reset in the middle of a pixel discards the partial sum.
    send(all_lanes(18'd512), all_lanes(18'd256), 1'b0, 18'd0, 1'b0);
    send(all_lanes(18'd512), all_lanes(18'd256), 1'b0, 18'd0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_busy_before_rst", busy, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_pixel", out_pixel, 0);
    chk("t6_rst_out_sat",   out_sat, 0);
    chk("t6_rst_busy",      busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(18'd8192, 1'b0);
    send(all_lanes(18'd512), all_lanes(18'd512), 1'b1, 18'd0, 1'b0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("results_received", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
